// File: rtl/cpu54_pkg.sv
// Shared definitions for the 54-instruction multi-cycle MIPS core: opcodes,
// function codes, the one-hot instruction index and the decoder FSM encoding.
package cpu54_pkg;

  localparam int NUM_INSTR = 54;
  localparam int INSTR_W   = 32;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN_TEQ     = 6'b110100;

  localparam logic [5:0] FN2_MUL    = 6'b000010;
  localparam logic [5:0] FN2_CLZ    = 6'b100000;

  localparam logic [4:0] RS_MFC0    = 5'b00000;
  localparam logic [4:0] RS_MTC0    = 5'b00100;
  localparam logic [4:0] RS_ERET    = 5'b10000;
  localparam logic [5:0] FN_ERET    = 6'b011000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  typedef enum logic [5:0] {
    I_ADDI, I_ADDIU, I_ANDI, I_ORI, I_SLTIU, I_LUI, I_XORI, I_SLTI,
    I_ADDU, I_AND, I_BEQ, I_BNE, I_J, I_JAL, I_JR, I_LW,
    I_XOR, I_NOR, I_OR, I_SLL, I_SLLV, I_SLTU, I_SRA, I_SRL,
    I_SUBU, I_SW, I_ADD, I_SUB, I_SLT, I_SRLV, I_SRAV, I_CLZ,
    I_DIVU, I_ERET, I_JALR, I_LB, I_LBU, I_LHU, I_SB, I_SH,
    I_LH, I_MFC0, I_MFHI, I_MFLO, I_MTC0, I_MTHI, I_MTLO, I_MUL,
    I_MULTU, I_SYSCALL, I_TEQ, I_BGEZ, I_BREAK, I_DIV
  } instr_idx_e;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADED  = 2'd1;
  localparam logic [1:0] ST_DECODED = 2'd2;

endpackage

// File: rtl/instr_match.sv
// Combinational matcher: 32-bit MIPS word -> one-hot instruction identity + illegal flag.
// Reserved-field checking is compiled in with DECODE_STRICT_EN.
module instr_match
  import cpu54_pkg::*;
(
  input  logic [31:0]          i_word,
  output logic [NUM_INSTR-1:0] o_onehot,
  output logic                 o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_hit;
  logic       w_ok;
  instr_idx_e w_idx;

  assign w_op = i_word[31:26];
  assign w_rs = i_word[25:21];
  assign w_rt = i_word[20:16];
  assign w_fn = i_word[5:0];

  always_comb begin
    w_hit = 1'b1;
    w_idx = I_SLL;
    case (w_op)
      OP_ADDI:  w_idx = I_ADDI;
      OP_ADDIU: w_idx = I_ADDIU;
      OP_ANDI:  w_idx = I_ANDI;
      OP_ORI:   w_idx = I_ORI;
      OP_SLTIU: w_idx = I_SLTIU;
      OP_LUI:   w_idx = I_LUI;
      OP_XORI:  w_idx = I_XORI;
      OP_SLTI:  w_idx = I_SLTI;
      OP_BEQ:   w_idx = I_BEQ;
      OP_BNE:   w_idx = I_BNE;
      OP_J:     w_idx = I_J;
      OP_JAL:   w_idx = I_JAL;
      OP_LW:    w_idx = I_LW;
      OP_SW:    w_idx = I_SW;
      OP_LB:    w_idx = I_LB;
      OP_LBU:   w_idx = I_LBU;
      OP_LHU:   w_idx = I_LHU;
      OP_SB:    w_idx = I_SB;
      OP_SH:    w_idx = I_SH;
      OP_LH:    w_idx = I_LH;
      OP_SPECIAL: begin
        case (w_fn)
          FN_ADDU:    w_idx = I_ADDU;
          FN_AND:     w_idx = I_AND;
          FN_JR:      w_idx = I_JR;
          FN_XOR:     w_idx = I_XOR;
          FN_NOR:     w_idx = I_NOR;
          FN_OR:      w_idx = I_OR;
          FN_SLL:     w_idx = I_SLL;
          FN_SLLV:    w_idx = I_SLLV;
          FN_SLTU:    w_idx = I_SLTU;
          FN_SRA:     w_idx = I_SRA;
          FN_SRL:     w_idx = I_SRL;
          FN_SUBU:    w_idx = I_SUBU;
          FN_ADD:     w_idx = I_ADD;
          FN_SUB:     w_idx = I_SUB;
          FN_SLT:     w_idx = I_SLT;
          FN_SRLV:    w_idx = I_SRLV;
          FN_SRAV:    w_idx = I_SRAV;
          FN_DIVU:    w_idx = I_DIVU;
          FN_JALR:    w_idx = I_JALR;
          FN_MFHI:    w_idx = I_MFHI;
          FN_MFLO:    w_idx = I_MFLO;
          FN_MTHI:    w_idx = I_MTHI;
          FN_MTLO:    w_idx = I_MTLO;
          FN_MULTU:   w_idx = I_MULTU;
          FN_SYSCALL: w_idx = I_SYSCALL;
          FN_TEQ:     w_idx = I_TEQ;
          FN_BREAK:   w_idx = I_BREAK;
          FN_DIV:     w_idx = I_DIV;
          default:    w_hit = 1'b0;
        endcase
      end
      OP_SPECIAL2: begin
        case (w_fn)
          FN2_MUL: w_idx = I_MUL;
          FN2_CLZ: w_idx = I_CLZ;
          default: w_hit = 1'b0;
        endcase
      end
      OP_COP0: begin
        if (w_rs == RS_MFC0)                         w_idx = I_MFC0;
        else if (w_rs == RS_MTC0)                    w_idx = I_MTC0;
        else if (w_rs == RS_ERET && w_fn == FN_ERET) w_idx = I_ERET;
        else                                         w_hit = 1'b0;
      end
      OP_REGIMM: begin
        if (w_rt == RT_BGEZ) w_idx = I_BGEZ;
        else                 w_hit = 1'b0;
      end
      default: w_hit = 1'b0;
    endcase
  end

`ifdef DECODE_STRICT_EN
  logic [4:0] w_rd;
  logic [4:0] w_sh;
  logic       w_rtype;
  logic       w_rsv_bad;

  assign w_rd    = i_word[15:11];
  assign w_sh    = i_word[10:6];
  assign w_rtype = (w_op == OP_SPECIAL) || (w_op == OP_SPECIAL2);

  // Only sll/srl/sra consume shamt; syscall/break/teq carry a code field there.
  always_comb begin
    w_rsv_bad = 1'b0;
    case (w_idx)
      I_SLL, I_SRL, I_SRA:                w_rsv_bad = (w_rs != 5'd0);
      I_SYSCALL, I_BREAK, I_TEQ:          w_rsv_bad = 1'b0;
      I_JR:                               w_rsv_bad = (w_rt != 5'd0) || (w_rd != 5'd0) || (w_sh != 5'd0);
      I_MULTU, I_DIVU, I_DIV, I_MTHI, I_MTLO:
                                          w_rsv_bad = (w_rd != 5'd0) || (w_sh != 5'd0);
      I_LUI:                              w_rsv_bad = (w_rs != 5'd0);
      default:                            w_rsv_bad = w_rtype && (w_sh != 5'd0);
    endcase
  end

  assign w_ok = w_hit && !w_rsv_bad;
`else
  logic w_unused_rsv;
  assign w_unused_rsv = ^i_word[15:6];
  assign w_ok         = w_hit;
`endif

  assign o_onehot  = w_ok ? ({{(NUM_INSTR-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign o_illegal = !w_ok;

endmodule

// File: rtl/instr_decoder.sv
// Instruction register + registered decode stage producing the one-hot decoded_instr
// vector and operand fields. Optional reserved-field checking: DECODE_STRICT_EN.
module instr_decoder #(
  parameter int INSTR_W   = 32,
  parameter int NUM_INSTR = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic                 ir_in,
  input  logic                 decode_ena,
  output logic [NUM_INSTR-1:0] decoded_instr,
  output logic                 decoded_valid,
  output logic                 illegal,
  output logic [INSTR_W-1:0]   ir_q,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [15:0]          imm16,
  output logic [25:0]          target26
);
  import cpu54_pkg::*;

  logic [1:0]           r_state;
  logic [INSTR_W-1:0]   r_ir;
  logic [NUM_INSTR-1:0] r_dec;
  logic                 r_ill;
  logic [4:0]           r_rs;
  logic [4:0]           r_rt;
  logic [4:0]           r_rd;
  logic [4:0]           r_sh;
  logic [15:0]          r_imm;
  logic [25:0]          r_tgt;

  logic [INSTR_W-1:0]   w_word;
  logic [NUM_INSTR-1:0] w_onehot;
  logic                 w_illegal;

  // Fetch-state bypass: with both strobes, decode the incoming word, not the stale IR.
  assign w_word = ir_in ? instr_in : r_ir;

  instr_match u_match (
    .i_word    (w_word),
    .o_onehot  (w_onehot),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ir    <= '0;
      r_dec   <= '0;
      r_ill   <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_sh    <= '0;
      r_imm   <= '0;
      r_tgt   <= '0;
    end else begin
      if (ir_in) r_ir <= instr_in;
      if (decode_ena) begin
        r_state <= ST_DECODED;
        r_dec   <= w_onehot;
        r_ill   <= w_illegal;
        r_rs    <= w_word[25:21];
        r_rt    <= w_word[20:16];
        r_rd    <= w_word[15:11];
        r_sh    <= w_word[10:6];
        r_imm   <= w_word[15:0];
        r_tgt   <= w_word[25:0];
      end else if (ir_in) begin
        r_state <= ST_LOADED;
      end
    end
  end

  assign decoded_valid = (r_state == ST_DECODED);
  assign decoded_instr = r_dec;
  assign illegal       = r_ill;
  assign ir_q          = r_ir;
  assign rs            = r_rs;
  assign rt            = r_rt;
  assign rd            = r_rd;
  assign shamt         = r_sh;
  assign imm16         = r_imm;
  assign target26      = r_tgt;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: pattern-table reference model, fixed
// fixtures, a sweep over all 54 encodings and randomized strobe/word traffic.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic        ir_in = 1'b0;
  logic        decode_ena = 1'b0;
  logic [53:0] decoded_instr;
  logic        decoded_valid;
  logic        illegal;
  logic [31:0] ir_q;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;

  instr_decoder dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .ir_in(ir_in), .decode_ena(decode_ena),
    .decoded_instr(decoded_instr), .decoded_valid(decoded_valid), .illegal(illegal),
    .ir_q(ir_q), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .target26(target26)
  );

  always #5 clk = ~clk;

`ifdef DECODE_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Pattern table: a word is instruction i when (w & t_mask[i]) == t_val[i];
  // t_rsv[i] marks bits that must be zero in strict decoding.
  logic [31:0] t_mask [54];
  logic [31:0] t_val  [54];
  logic [31:0] t_rsv  [54];

  // Behavioural decoder state
  logic [31:0] m_ir   = '0;
  logic [31:0] m_word = '0;
  logic [53:0] m_dec  = '0;
  logic        m_ill  = 1'b0;
  logic        m_vld  = 1'b0;

  localparam logic [31:0] SH_M = 32'h0000_07C0;
  localparam logic [31:0] RS_M = 32'h03E0_0000;
  localparam logic [31:0] RT_M = 32'h001F_0000;
  localparam logic [31:0] RD_M = 32'h0000_F800;

  task automatic top(input int i, input logic [5:0] op);
    t_mask[i] = 32'hFC00_0000; t_val[i] = {op, 26'd0}; t_rsv[i] = '0;
  endtask

  task automatic rty(input int i, input logic [5:0] op, input logic [5:0] fn);
    t_mask[i] = 32'hFC00_003F; t_val[i] = {op, 20'd0, fn}; t_rsv[i] = SH_M;
  endtask

  task automatic build_table();
    top(0, 6'd8);  top(1, 6'd9);  top(2, 6'd12); top(3, 6'd13); top(4, 6'd11);
    top(5, 6'd15); top(6, 6'd14); top(7, 6'd10);
    rty(8, 6'd0, 6'd33);  rty(9, 6'd0, 6'd36); top(10, 6'd4); top(11, 6'd5);
    top(12, 6'd2); top(13, 6'd3); rty(14, 6'd0, 6'd8); top(15, 6'd35);
    rty(16, 6'd0, 6'd38); rty(17, 6'd0, 6'd39); rty(18, 6'd0, 6'd37); rty(19, 6'd0, 6'd0);
    rty(20, 6'd0, 6'd4);  rty(21, 6'd0, 6'd43); rty(22, 6'd0, 6'd3);  rty(23, 6'd0, 6'd2);
    rty(24, 6'd0, 6'd35); top(25, 6'd43); rty(26, 6'd0, 6'd32); rty(27, 6'd0, 6'd34);
    rty(28, 6'd0, 6'd42); rty(29, 6'd0, 6'd6);  rty(30, 6'd0, 6'd7);  rty(31, 6'd28, 6'd32);
    rty(32, 6'd0, 6'd27);
    t_mask[33] = 32'hFFE0_003F; t_val[33] = 32'h4200_0018; t_rsv[33] = '0;
    rty(34, 6'd0, 6'd9);
    top(35, 6'd32); top(36, 6'd36); top(37, 6'd37); top(38, 6'd40); top(39, 6'd41); top(40, 6'd33);
    t_mask[41] = 32'hFFE0_0000; t_val[41] = 32'h4000_0000; t_rsv[41] = '0;
    rty(42, 6'd0, 6'd16); rty(43, 6'd0, 6'd18);
    t_mask[44] = 32'hFFE0_0000; t_val[44] = 32'h4080_0000; t_rsv[44] = '0;
    rty(45, 6'd0, 6'd17); rty(46, 6'd0, 6'd19); rty(47, 6'd28, 6'd2); rty(48, 6'd0, 6'd25);
    rty(49, 6'd0, 6'd12); rty(50, 6'd0, 6'd52);
    t_mask[51] = 32'hFC1F_0000; t_val[51] = 32'h0401_0000; t_rsv[51] = '0;
    rty(52, 6'd0, 6'd13); rty(53, 6'd0, 6'd26);
    // Shifts by immediate use shamt but reserve rs; trap codes overlay shamt.
    t_rsv[19] = RS_M; t_rsv[22] = RS_M; t_rsv[23] = RS_M;
    t_rsv[49] = '0;   t_rsv[50] = '0;   t_rsv[52] = '0;
    t_rsv[14] = SH_M | RT_M | RD_M;
    t_rsv[48] = SH_M | RD_M; t_rsv[32] = SH_M | RD_M; t_rsv[53] = SH_M | RD_M;
    t_rsv[45] = SH_M | RD_M; t_rsv[46] = SH_M | RD_M;
    t_rsv[5]  = RS_M;
  endtask

  function automatic void ref_decode(input logic [31:0] w, output logic [53:0] oh, output logic il);
    int hits = 0;
    int idx = 0;
    for (int i = 0; i < 54; i++)
      if ((w & t_mask[i]) == t_val[i]) begin hits++; idx = i; end
    oh = '0;
    il = 1'b1;
    if (hits == 1 && (!STRICT || (w & t_rsv[idx]) == 32'd0)) begin
      oh[idx] = 1'b1;
      il = 1'b0;
    end
  endfunction

  task automatic model_step(input logic ir, input logic de, input logic [31:0] w);
    logic [31:0] word;
    if (de) begin
      word = ir ? w : m_ir;
      ref_decode(word, m_dec, m_ill);
      m_word = word;
      m_vld  = 1'b1;
    end else if (ir) begin
      m_vld = 1'b0;
    end
    if (ir) m_ir = w;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ir_q",          64'(ir_q),          64'(m_ir));
      chk("decoded_valid", 64'(decoded_valid), 64'(m_vld));
      chk("decoded_instr", 64'(decoded_instr), 64'(m_dec));
      chk("illegal",       64'(illegal),       64'(m_ill));
      chk("rs",            64'(rs),            64'(m_word[25:21]));
      chk("rt",            64'(rt),            64'(m_word[20:16]));
      chk("rd",            64'(rd),            64'(m_word[15:11]));
      chk("shamt",         64'(shamt),         64'(m_word[10:6]));
      chk("imm16",         64'(imm16),         64'(m_word[15:0]));
      chk("target26",      64'(target26),      64'(m_word[25:0]));
    end
  end

  task automatic step(input logic ir, input logic de, input logic [31:0] w);
    ir_in = ir; decode_ena = de; instr_in = w;
    @(posedge clk);
    model_step(ir, de, w);
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_word();
    int i;
    logic [31:0] w;
    if ($urandom_range(0, 3) == 0) return $urandom;
    i = $urandom_range(0, 53);
    w = t_val[i] | ($urandom & ~t_mask[i]);
    if ($urandom_range(0, 1) == 1) w = w & ~t_rsv[i];
    return w;
  endfunction

  initial begin
    logic [53:0] onehot;
    logic [31:0] w;
    build_table();

    // Strobes during reset must have no effect
    ir_in = 1'b1; decode_ena = 1'b1; instr_in = 32'h2008_0005;
    @(posedge clk); @(negedge clk);
    chk("rst_hold_valid", 64'(decoded_valid), 64'd0);
    chk("rst_hold_ir",    64'(ir_q),          64'd0);
    chk("rst_hold_dec",   64'(decoded_instr), 64'd0);
    ir_in = 1'b0; decode_ena = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // Decode from EMPTY sees IR = 0, i.e. sll
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("empty_dec_sll", 64'(decoded_instr), 64'd1 << 19);
    chk("empty_dec_vld", 64'(decoded_valid), 64'd1);

    step(1'b1, 1'b1, 32'h2008_0005);
    chk("addi_bit",   64'(decoded_instr), 64'd1);
    chk("addi_rt",    64'(rt),            64'd8);
    chk("addi_imm",   64'(imm16),         64'h5);
    chk("addi_vld",   64'(decoded_valid), 64'd1);
    chk("addi_ill",   64'(illegal),       64'd0);

    step(1'b1, 1'b0, 32'h012A_4021);
    chk("addu_load_vld", 64'(decoded_valid), 64'd0);
    chk("addu_load_ir",  64'(ir_q),          64'h012A_4021);
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("addu_bit", 64'(decoded_instr), 64'd1 << 8);
    chk("addu_rs",  64'(rs), 64'd9);
    chk("addu_rt",  64'(rt), 64'd10);
    chk("addu_rd",  64'(rd), 64'd8);
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("redecode_bit", 64'(decoded_instr), 64'd1 << 8);

    step(1'b1, 1'b1, 32'hFC00_0000);
    chk("illegal_dec", 64'(decoded_instr), 64'd0);
    chk("illegal_flag", 64'(illegal), 64'd1);
    chk("illegal_vld", 64'(decoded_valid), 64'd1);

    step(1'b1, 1'b1, 32'h0120_F809);
    chk("jalr_bit", 64'(decoded_instr), 64'd1 << 34);
    step(1'b1, 1'b1, 32'h4008_6000);
    chk("mfc0_bit", 64'(decoded_instr), 64'd1 << 41);
    step(1'b1, 1'b1, 32'h4200_0018);
    chk("eret_bit", 64'(decoded_instr), 64'd1 << 33);
    step(1'b1, 1'b1, 32'h0421_0010);
    chk("bgez_bit", 64'(decoded_instr), 64'd1 << 51);

    step(1'b1, 1'b1, 32'h012A_4061);
`ifdef DECODE_STRICT_EN
    chk("addu_shamt_ill", 64'(illegal), 64'd1);
    chk("addu_shamt_dec", 64'(decoded_instr), 64'd0);
`else
    chk("addu_shamt_ill", 64'(illegal), 64'd0);
    chk("addu_shamt_dec", 64'(decoded_instr), 64'd1 << 8);
`endif

    for (int i = 0; i < 54; i++) begin
      w = (t_val[i] | ($urandom & ~t_mask[i])) & ~t_rsv[i];
      step(1'b1, 1'b1, w);
      onehot = 54'd1 << i;
      chk($sformatf("sweep_%0d", i), 64'(decoded_instr), 64'(onehot));
      chk($sformatf("sweep_ill_%0d", i), 64'(illegal), 64'd0);
    end

    // Asynchronous reset between edges while DECODED
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dec", 64'(decoded_instr), 64'd0);
    chk("async_rst_vld", 64'(decoded_valid), 64'd0);
    chk("async_rst_ir",  64'(ir_q),          64'd0);
    chk("async_rst_tgt", 64'(target26),      64'd0);
    m_ir = '0; m_word = '0; m_dec = '0; m_ill = 1'b0; m_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h2008_0005);
    chk("post_rst_vld", 64'(decoded_valid), 64'd0);

    for (int n = 0; n < 800; n++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), gen_word());

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
